// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: arbitrates memory wait, mult/div
// occupancy of EX, load-use hazards and taken-branch squash; counts stall/flush cycles.
//
// state   | meaning
// IDLE    | no mult/div resident in EX
// MD_BUSY | mult/div occupying EX, md_cnt holds remaining hold cycles
module pipeline_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_re,
  input  logic             id_rt_re,
  input  logic             ex_load,
  input  logic [4:0]       ex_wd,
  input  logic             ex_md_start,
  input  logic             mem_busy,
  input  logic             id_branch_taken,
  output logic [4:0]       stall,
  output logic [4:0]       flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {IDLE, MD_BUSY} state_t;

  state_t     state;
  logic [7:0] md_cnt;
  logic       rs_hit, rt_hit, load_use, md_hold;

  always_comb begin
    rs_hit   = id_rs_re && (id_rs == ex_wd);
    rt_hit   = id_rt_re && (id_rt == ex_wd);
    load_use = ex_load && (ex_wd != 5'd0) && (rs_hit || rt_hit);
    md_hold  = ((state == IDLE) && ex_md_start) || ((state == MD_BUSY) && (md_cnt != 8'd0));
    stall    = 5'b00000;
    flush    = 5'b00000;
    md_done  = 1'b0;
    if (!rst) begin
      // Fixed priority; each row freezes everything upstream and bubbles the next stage.
      if (mem_busy) begin
        stall = 5'b01111;
        flush = 5'b10000;
      end else if (md_hold) begin
        stall = 5'b00111;
        flush = 5'b01000;
      end else if (load_use) begin
        stall = 5'b00011;
        flush = 5'b00100;
      end else if (id_branch_taken) begin
        flush = 5'b00010;
      end
      md_done = (state == MD_BUSY) && !mem_busy && (md_cnt == 8'd0);
    end
  end

  assign md_busy = (state == MD_BUSY) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      md_cnt       <= 8'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall != 5'b00000) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush != 5'b00000) flush_count  <= flush_count + CNT_W'(1);
      if (!mem_busy) begin
        case (state)
          IDLE: begin
            if (ex_md_start) begin
              state  <= MD_BUSY;
              md_cnt <= 8'(MD_LATENCY - 2);
            end
          end
          MD_BUSY: begin
            if (md_cnt != 8'd0) md_cnt <= md_cnt - 8'd1;
            else                state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: constant vector table, hand sequences for the mult/div,
// mem-wait and reset corners, and random stimulus against a cycle-level model.
module tb_pipeline_ctrl;

  localparam int MDL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_wd;
  logic        id_rs_re, id_rt_re, ex_load, ex_md_start, mem_busy, id_branch_taken;
  logic [4:0]  stall, flush;
  logic        md_busy, md_done;
  logic [31:0] stall_cycles, flush_count;

  int n_vec = 0;
  int n_err = 0;

  // Model state: how many productive EX cycles the resident mult/div has spent (0 = none).
  int          m_el = 0;
  logic [31:0] m_sc = 0;
  logic [31:0] m_fc = 0;

  typedef struct {
    logic [4:0] rs, rt;
    logic       rs_re, rt_re, ld;
    logic [4:0] wd;
    logic       md, mb, br;
  } in_t;

  typedef struct {
    in_t        i;
    logic [4:0] es, ef;
  } row_t;

  pipeline_ctrl #(.MD_LATENCY(MDL), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
    .ex_load(ex_load), .ex_wd(ex_wd), .ex_md_start(ex_md_start),
    .mem_busy(mem_busy), .id_branch_taken(id_branch_taken),
    .stall(stall), .flush(flush), .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input int rs, input int rt, input bit rs_re, input bit rt_re,
                             input bit ld, input int wd, input bit md, input bit mb,
                             input bit br);
    in_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rs_re = rs_re; v.rt_re = rt_re;
    v.ld = ld; v.wd = 5'(wd); v.md = md; v.mb = mb; v.br = br;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_out(output logic [4:0] es, output logic [4:0] ef,
                           output logic ed, output logic eb);
    bit hold, lu;
    es = 0; ef = 0; ed = 0; eb = 0;
    if (!rst) begin
      hold = (m_el == 0 && ex_md_start) || (m_el != 0 && m_el < MDL - 1);
      lu   = ex_load && ex_wd != 0 &&
             ((id_rs_re && id_rs == ex_wd) || (id_rt_re && id_rt == ex_wd));
      eb   = (m_el != 0);
      ed   = (m_el == MDL - 1) && !mem_busy;
      if (mem_busy)             begin es = 5'b01111; ef = 5'b10000; end
      else if (hold)            begin es = 5'b00111; ef = 5'b01000; end
      else if (lu)              begin es = 5'b00011; ef = 5'b00100; end
      else if (id_branch_taken) ef = 5'b00010;
    end
  endtask

  task automatic model_update(input logic [4:0] es, input logic [4:0] ef);
    if (rst) begin
      m_el = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (es != 0) m_sc++;
      if (ef != 0) m_fc++;
      if (!mem_busy) begin
        if (m_el == 0) begin
          if (ex_md_start) m_el = 1;
        end else if (m_el == MDL - 1) m_el = 0;
        else m_el++;
      end
    end
  endtask

  task automatic step(input in_t v, input logic r, output logic [4:0] s, output logic [4:0] f,
                      output logic d, output logic b);
    logic [4:0] es, ef;
    logic       ed, eb;
    rst = r;
    id_rs = v.rs; id_rt = v.rt; id_rs_re = v.rs_re; id_rt_re = v.rt_re;
    ex_load = v.ld; ex_wd = v.wd; ex_md_start = v.md; mem_busy = v.mb;
    id_branch_taken = v.br;
    #2;
    s = stall; f = flush; d = md_done; b = md_busy;
    model_out(es, ef, ed, eb);
    chk("stall", 32'(s), 32'(es));
    chk("flush", 32'(f), 32'(ef));
    chk("md_done", 32'(d), 32'(ed));
    chk("md_busy", 32'(b), 32'(eb));
    @(posedge clk);
    model_update(es, ef);
    #1;
    chk("stall_cycles", stall_cycles, m_sc);
    chk("flush_count", flush_count, m_fc);
  endtask

  row_t       tbl[11];
  in_t        idle_v;
  logic [4:0] s, f;
  logic       d, b;

  initial begin
    tbl[0]  = '{i: mk(5, 0, 1, 0, 1, 5, 0, 0, 0), es: 5'b00011, ef: 5'b00100};
    tbl[1]  = '{i: mk(5, 0, 1, 0, 1, 0, 0, 0, 0), es: 5'b00000, ef: 5'b00000};
    tbl[2]  = '{i: mk(0, 0, 1, 1, 1, 0, 0, 0, 0), es: 5'b00000, ef: 5'b00000};
    tbl[3]  = '{i: mk(5, 0, 0, 0, 1, 5, 0, 0, 0), es: 5'b00000, ef: 5'b00000};
    tbl[4]  = '{i: mk(1, 7, 0, 1, 1, 7, 0, 0, 0), es: 5'b00011, ef: 5'b00100};
    tbl[5]  = '{i: mk(1, 7, 1, 0, 1, 7, 0, 0, 0), es: 5'b00000, ef: 5'b00000};
    tbl[6]  = '{i: mk(7, 7, 1, 1, 0, 7, 0, 0, 0), es: 5'b00000, ef: 5'b00000};
    tbl[7]  = '{i: mk(0, 0, 0, 0, 0, 0, 0, 0, 1), es: 5'b00000, ef: 5'b00010};
    tbl[8]  = '{i: mk(3, 9, 1, 1, 1, 9, 0, 0, 1), es: 5'b00011, ef: 5'b00100};
    tbl[9]  = '{i: mk(3, 9, 1, 1, 1, 3, 0, 1, 1), es: 5'b01111, ef: 5'b10000};
    tbl[10] = '{i: mk(0, 0, 0, 0, 0, 0, 0, 1, 0), es: 5'b01111, ef: 5'b10000};
    idle_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    id_rs = 0; id_rt = 0; id_rs_re = 0; id_rt_re = 0; ex_load = 0; ex_wd = 0;
    ex_md_start = 0; mem_busy = 0; id_branch_taken = 0;
    @(posedge clk); #1;

    // Reset: outputs quiet even with hazards present.
    step(mk(5, 0, 1, 0, 1, 5, 1, 1, 1), 1'b1, s, f, d, b);
    chk("rst_stall", 32'(s), 0);
    chk("rst_flush", 32'(f), 0);
    chk("rst_cnt", stall_cycles, 0);

    // Vector table, applied from IDLE with no mult/div.
    for (int k = 0; k < 11; k++) begin
      step(tbl[k].i, 1'b0, s, f, d, b);
      chk($sformatf("tbl%0d_stall", k), 32'(s), 32'(tbl[k].es));
      chk($sformatf("tbl%0d_flush", k), 32'(f), 32'(tbl[k].ef));
    end

    // Load-use lasts one cycle once the load moves on.
    step(idle_v, 1'b1, s, f, d, b);
    step(mk(5, 0, 1, 0, 1, 5, 0, 0, 0), 1'b0, s, f, d, b);
    chk("lu_stall", 32'(s), 32'h3);
    step(idle_v, 1'b0, s, f, d, b);
    chk("lu_after", 32'(s), 0);
    chk("lu_stall_cycles", stall_cycles, 1);

    // Mult/div held in EX for MDL cycles.
    for (int c = 0; c <= MDL - 1; c++) begin
      step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, s, f, d, b);
      chk($sformatf("md_c%0d_stall", c), 32'(s), (c < MDL - 1) ? 32'h7 : 32'h0);
      chk($sformatf("md_c%0d_done", c), 32'(d), (c == MDL - 1) ? 1 : 0);
      chk($sformatf("md_c%0d_busy", c), 32'(b), (c >= 1) ? 1 : 0);
    end
    step(idle_v, 1'b0, s, f, d, b);

    // Three mem_busy cycles inside MD_BUSY push md_done out by three.
    for (int c = 0; c <= MDL + 2; c++) begin
      step(mk(0, 0, 0, 0, 0, 0, 1, (c >= 3 && c <= 5), 0), 1'b0, s, f, d, b);
      chk($sformatf("mdmb_c%0d_stall", c), 32'(s),
          (c >= 3 && c <= 5) ? 32'hF : (c < MDL + 2) ? 32'h7 : 32'h0);
      chk($sformatf("mdmb_c%0d_done", c), 32'(d), (c == MDL + 2) ? 1 : 0);
    end
    step(idle_v, 1'b0, s, f, d, b);

    // Branch loses to load-use, then re-asserts alone.
    step(idle_v, 1'b1, s, f, d, b);
    step(mk(4, 0, 1, 0, 1, 4, 0, 0, 1), 1'b0, s, f, d, b);
    chk("brlu_flush", 32'(f), 32'h4);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, s, f, d, b);
    chk("br_flush", 32'(f), 32'h2);
    chk("br_flush_count", flush_count, 2);

    // Reset while md_cnt is 3: back to IDLE with no done pulse.
    for (int c = 0; c < 4; c++) step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, s, f, d, b);
    step(idle_v, 1'b1, s, f, d, b);
    chk("mdrst_done", 32'(d), 0);
    chk("mdrst_busy", 32'(b), 0);
    chk("mdrst_cnt", stall_cycles, 0);
    step(idle_v, 1'b0, s, f, d, b);
    chk("mdrst_after_busy", 32'(b), 0);
    chk("mdrst_after_stall", 32'(s), 0);
    chk("mdrst_after_done", 32'(d), 0);

    // Random stimulus against the model.
    for (int c = 0; c < 1500; c++) begin
      step(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
              $urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0), s, f, d, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It decides each cycle which pipeline registers hold and which load a bubble. Hold and bubble controls go to the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It resolves memory-wait, multi-cycle mult/div occupancy of EX, load-use hazards and taken-branch squash under a fixed priority. It also keeps stall and flush performance counters.

Parameters:
MD_LATENCY, 8, total cycles a mult/div occupies EX (legal range 2..255)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  reset
id_rs  in  5  rs address of the instruction in ID
id_rt  in  5  rt address of the instruction in ID
id_rs_re  in  1  ID instruction reads rs
id_rt_re  in  1  ID instruction reads rt
ex_load  in  1  instruction in EX is a load
ex_wd  in  5  destination register of the instruction in EX
ex_md_start  in  1  instruction in EX is mult/div; held high while it stays in EX
mem_busy  in  1  MEM-stage memory access not complete this cycle
id_branch_taken  in  1  branch/jump resolved taken in ID
stall  out  5  hold enables; bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB
flush  out  5  bubble enables, same bit order; the register loads all-zero (nop)
md_busy  out  1  FSM is in MD_BUSY
md_done  out  1  one-cycle pulse on the cycle mult/div leaves EX
stall_cycles  out  CNT_W  count of cycles with stall != 0
flush_count  out  CNT_W  count of cycles with flush != 0

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: state=IDLE, md_cnt=0, stall_cycles=0, flush_count=0. While rst is high, stall=0, flush=0, md_done=0 and md_busy=0.
- stall, flush and md_done are combinational from state, md_cnt and inputs. State, md_cnt and the counters are registered.
- A flush bit is never set together with the matching stall bit.
- FSM states: IDLE, MD_BUSY.
  - IDLE & ex_md_start & !mem_busy: go to MD_BUSY; md_cnt <= MD_LATENCY-2.
  - MD_BUSY & !mem_busy & md_cnt!=0: md_cnt decrements.
  - MD_BUSY & !mem_busy & md_cnt==0: return to IDLE; md_done=1 this cycle.
  - mem_busy freezes state and md_cnt.
  - ex_md_start is ignored in MD_BUSY.
- Condition "md_hold" = (IDLE & ex_md_start) | (MD_BUSY & md_cnt!=0). EX residence is exactly MD_LATENCY cycles.
- Condition "load_use" = ex_load & ex_wd!=0 & ((id_rs_re & id_rs==ex_wd) | (id_rt_re & id_rt==ex_wd)).
- Priority, highest first; exactly one row applies:
  1. mem_busy: stall=5'b01111, flush=5'b10000.
  2. md_hold: stall=5'b00111, flush=5'b01000.
  3. load_use: stall=5'b00011, flush=5'b00100. Lasts one cycle naturally: the load advances to MEM.
  4. id_branch_taken: stall=0, flush=5'b00010 (squash the fetched successor; no delay slot).
  5. else: stall=0, flush=0.
- A branch suppressed by rows 1-3 stays in ID and re-asserts. No branch state is stored.
- Counters: increment by 1 on each qualifying non-reset cycle. They wrap modulo 2^CNT_W with no saturation.
- Register r0 never produces load_use.
- Reset mid-mult/div: FSM returns to IDLE immediately. No md_done is produced.

Test Plan:
- Load to r5 in EX (ex_load=1, ex_wd=5), ID reads rs=5 -> one cycle of stall=00011, flush=00100; next cycle with ex_load=0 gives stall=0. stall_cycles=1.
- Same case with ex_wd=0 or id_rs_re=0 -> stall=0, flush=0.
- ex_md_start held high from cycle 0, MD_LATENCY=8 -> stall=00111 on cycles 0-6, stall=0 on cycle 7, md_done=1 only on cycle 7, md_busy high on cycles 1-7.
- mem_busy high for 3 cycles in the middle of MD_BUSY -> stall=01111, flush=10000 on those cycles and md_cnt frozen; md_done is delayed by exactly 3 cycles.
- id_branch_taken together with load_use -> load-use row wins (flush=00100); next cycle branch alone gives flush=00010. flush_count=2.
- rst asserted at MD_BUSY md_cnt=3 -> next cycle md_busy=0, stall=0, counters=0; no md_done pulse.
